rom_fetch: RTL and testbench

Instruction fetch unit: initiator side of the 8-bit-address / 16-bit-data combinational ROM port. Drives a program counter onto the ROM address, captures the returned word into a 2-entry buffer, and presents instructions with their PC to the downstream decoder over a valid/ready handshake. Supports PC redirect (branch/jump) with buffer flush and a fetch-enable stall.

---
 rtl/luna_pkg.sv | 19 +
 rtl/rom_fetch_if.sv | 48 ++++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/rom_fetch.sv | 63 ++++++
 tb/tb_rom_fetch.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/luna_pkg.sv
`default_nettype none
// ============================================================================
// Module   : luna_pkg
// Purpose  : Shared fetch/decode widths, reset PC and fetch entry type.
// Revision : 1.0
// ============================================================================
package luna_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] word;
   } fetch_entry_t;

endpackage : luna_pkg
`default_nettype wire

// File: rtl/rom_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_if
// Purpose  : ROM port, decoder handshake and redirect/stall controls.
// Revision : 1.0
// ============================================================================
interface rom_fetch_if
   import luna_pkg::*;
#(
   parameter int ADDR_W = luna_pkg::ADDR_W,
   parameter int DATA_W = luna_pkg::DATA_W
);
   logic              fetch_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      input  fetch_en,
      output rom_addr,
      input  rom_data,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      output fetch_en,
      input  rom_addr,
      output rom_data,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready,
      output redirect_valid,
      output redirect_pc
   );

endinterface : rom_fetch_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : 2-entry FIFO of fetch entries with flush; head read from registers.
// Revision : 1.0
// ============================================================================
module fetch_fifo
   import luna_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         // When full, a simultaneous pop frees the slot the push overwrites.
         if (push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch
// Purpose  : Instruction fetch unit driving a combinational ROM port.
// Revision : 1.0
// ============================================================================
module rom_fetch
   import luna_pkg::*;
#(
   parameter int                ADDR_W   = luna_pkg::ADDR_W,
   parameter int                DATA_W   = luna_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = luna_pkg::RESET_PC
)(
   input  logic        clk,
   input  logic        rst_n,
   rom_fetch_if.master bus
);

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [1:0]        w_count;
   logic              w_valid;
   logic              w_push;
   logic              w_pop;
   fetch_entry_t      w_wr_entry;
   fetch_entry_t      w_head;

   assign w_valid = (w_count != 2'd0);
   assign w_pop   = w_valid && bus.instr_ready;
   assign w_push  = bus.fetch_en && !bus.redirect_valid &&
                    ((w_count < 2'd2) || w_pop);

   assign w_wr_entry.pc   = r_fetch_pc;
   assign w_wr_entry.word = bus.rom_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
      end else if (bus.redirect_valid) begin
         r_fetch_pc <= bus.redirect_pc;
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + 1'b1;
      end
   end

   // Redirect flushes; a pop in the same cycle has already been accepted.
   fetch_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .flush (bus.redirect_valid),
      .din   (w_wr_entry),
      .count (w_count),
      .head  (w_head)
   );

   assign bus.rom_addr    = r_fetch_pc;
   assign bus.instr       = w_head.word;
   assign bus.instr_pc    = w_head.pc;
   assign bus.instr_valid = w_valid;

endmodule : rom_fetch
`default_nettype wire

// File: tb/tb_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch
// Purpose  : Directed self-checking bench for rom_fetch with {A5, addr} ROM.
// Revision : 1.0
// ============================================================================
module tb_rom_fetch;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   rom_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

   rom_fetch #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.rom_data = {8'hA5, bus.rom_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_head(input string tag, input logic [7:0] pc);
      logic [15:0] w_exp;
      w_exp = {8'hA5, pc};
      check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
      check({tag, "_pc"},    32'(bus.instr_pc),    32'(pc));
      check({tag, "_instr"}, 32'(bus.instr),       32'(w_exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks           = 0;
      n_errors           = 0;
      rst_n              = 1'b0;
      bus.fetch_en       = 1'b1;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 8'h00;

      // Reset state and streaming from 0x00
      tick();
      tick();
      #2 rst_n = 1'b1;
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", 32'(bus.instr), 32'd0);
      check("rst_pc", 32'(bus.instr_pc), 32'd0);
      check("rst_addr", 32'(bus.rom_addr), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_head("stream", 8'(i));
      end

      // Stall from reset: buffer fills with 0x00,0x01, then drains in order
      rst_n = 1'b0;
      #2;
      check("rst2_valid", 32'(bus.instr_valid), 32'd0);
      check("rst2_addr", 32'(bus.rom_addr), 32'd0);
      bus.instr_ready = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_head("full_head", 8'h00);
      check("full_addr", 32'(bus.rom_addr), 32'h02);
      bus.instr_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         check_head("refill", 8'(i));
      end

      // Redirect with a same-cycle pop: 0x10 accepted, 0x11 dropped
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h10;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      tick();
      tick();
      check_head("pre_redir", 8'h10);
      check("pre_redir_addr", 32'(bus.rom_addr), 32'h12);
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h40;
      tick();
      bus.redirect_valid = 1'b0;
      check("bubble_valid", 32'(bus.instr_valid), 32'd0);
      check("bubble_addr", 32'(bus.rom_addr), 32'h40);
      tick();
      check_head("redir_a", 8'h40);
      tick();
      check_head("redir_b", 8'h41);

      // PC wraparound 0xFF -> 0x00
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'hFE;
      tick();
      bus.redirect_valid = 1'b0;
      tick();
      check_head("wrap_fe", 8'hFE);
      tick();
      check_head("wrap_ff", 8'hFF);
      tick();
      check_head("wrap_00", 8'h00);
      tick();
      check_head("wrap_01", 8'h01);

      // Fetch disable: buffer drains, PC holds, then resumes
      bus.instr_ready = 1'b0;
      tick();
      check_head("hold_01", 8'h01);
      check("hold_addr", 32'(bus.rom_addr), 32'h03);
      bus.fetch_en    = 1'b0;
      bus.instr_ready = 1'b1;
      tick();
      check_head("drain_02", 8'h02);
      tick();
      check("drain_valid", 32'(bus.instr_valid), 32'd0);
      check("drain_addr", 32'(bus.rom_addr), 32'h03);
      tick();
      check("idle_valid", 32'(bus.instr_valid), 32'd0);
      check("idle_addr", 32'(bus.rom_addr), 32'h03);
      bus.fetch_en = 1'b1;
      tick();
      check_head("resume_03", 8'h03);
      tick();
      check_head("resume_04", 8'h04);

      // Asynchronous reset mid-stream
      #3 rst_n = 1'b0;
      #1;
      check("async_valid", 32'(bus.instr_valid), 32'd0);
      check("async_addr", 32'(bus.rom_addr), 32'h00);
      check("async_pc", 32'(bus.instr_pc), 32'h00);
      #2 rst_n = 1'b1;
      tick();
      check_head("restart_00", 8'h00);
      tick();
      check_head("restart_01", 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rom_fetch
`default_nettype wire
